// File: rtl/request_unit.sv
// request_unit: shares one single-ported RAM between instruction fetch and
// data loads/stores. The sequence is fetch, execute, then an optional data
// access. Each RAM request is held until the RAM deasserts busy_o.
//
// state | meaning
// FETCH | read instruction at imemaddr, capture into imemload on completion
// EXEC  | one idle cycle; cuOP decides whether a data access follows
// DATA  | load or store at dmmaddr, capture load data into dmmload
module request_unit (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        busy_o,
  input  logic [31:0] imemaddr,
  input  logic [31:0] dmmaddr,
  input  logic [31:0] dmmstore,
  input  logic [31:0] ramload,
  input  logic [5:0]  cuOP,
  output logic        Ren,
  output logic        Wen,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic [31:0] imemload,
  output logic [31:0] dmmload
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    DATA  = 2'd2
  } state_t;

  // Control-unit encodings for the memory opcodes (LB..LHU, SB..SW)
  localparam logic [5:0] OP_LOAD_LO  = 6'd10;
  localparam logic [5:0] OP_LOAD_HI  = 6'd14;
  localparam logic [5:0] OP_STORE_LO = 6'd15;
  localparam logic [5:0] OP_STORE_HI = 6'd17;

  state_t      state_q, state_d;
  logic [31:0] imemload_q, imemload_d;
  logic [31:0] dmmload_q, dmmload_d;
  logic        is_load, is_store;

  assign is_load  = (cuOP >= OP_LOAD_LO)  && (cuOP <= OP_LOAD_HI);
  assign is_store = (cuOP >= OP_STORE_LO) && (cuOP <= OP_STORE_HI);

  // State and captured read data; reset abandons any in-flight access
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= FETCH;
      imemload_q <= 32'd0;
      dmmload_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      imemload_q <= imemload_d;
      dmmload_q  <= dmmload_d;
    end
  end

  // Next state, capture enables and live RAM request decode
  always_comb begin
    state_d    = state_q;
    imemload_d = imemload_q;
    dmmload_d  = dmmload_q;
    Ren        = 1'b0;
    Wen        = 1'b0;
    ramaddr    = imemaddr;
    ramstore   = 32'd0;
    unique case (state_q)
      FETCH: begin
        Ren = 1'b1;
        if (!busy_o) begin
          imemload_d = ramload;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        state_d = (is_load || is_store) ? DATA : FETCH;
      end
      DATA: begin
        ramaddr = dmmaddr;
        if (is_load) begin
          Ren = 1'b1;
        end else if (is_store) begin
          Wen      = 1'b1;
          ramstore = dmmstore;
        end
        if (!busy_o) begin
          if (is_load) begin
            dmmload_d = ramload;
          end
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign imemload = imemload_q;
  assign dmmload  = dmmload_q;

endmodule

// File: tb/tb_request_unit.sv
module tb_request_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        busy_o;
  logic [31:0] imemaddr, dmmaddr, dmmstore, ramload;
  logic [5:0]  cuOP;
  logic        Ren, Wen;
  logic [31:0] ramaddr, ramstore, imemload, dmmload;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: phase of the instruction cycle and captured words
  typedef enum int {PH_FETCH, PH_EXEC, PH_DATA} phase_t;
  phase_t      m_ph;
  logic [31:0] m_im, m_dm;

  request_unit dut (
    .CLK(CLK), .nRST(nRST), .busy_o(busy_o),
    .imemaddr(imemaddr), .dmmaddr(dmmaddr), .dmmstore(dmmstore),
    .ramload(ramload), .cuOP(cuOP),
    .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr), .ramstore(ramstore),
    .imemload(imemload), .dmmload(dmmload)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic bit op_load(input logic [5:0] op);
    return op >= 6'd10 && op <= 6'd14;
  endfunction

  function automatic bit op_store(input logic [5:0] op);
    return op >= 6'd15 && op <= 6'd17;
  endfunction

  // one clock: drive inputs, check the request and registered outputs,
  // clock the DUT, then advance the model
  task automatic cycle(input logic rst_n, input logic busy, input logic [5:0] op,
                       input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] ds, input logic [31:0] rl, input string tag);
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    @(negedge CLK);
    nRST = rst_n; busy_o = busy; cuOP = op;
    imemaddr = ia; dmmaddr = da; dmmstore = ds; ramload = rl;
    #1;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = ia; e_store = 32'd0;
    if (m_ph == PH_FETCH) e_ren = 1'b1;
    if (m_ph == PH_DATA) begin
      e_addr = da;
      if (op_load(op)) e_ren = 1'b1;
      if (op_store(op)) begin e_wen = 1'b1; e_store = ds; end
    end
    check_eq({tag, ".Ren"}, {31'd0, Ren}, {31'd0, e_ren});
    check_eq({tag, ".Wen"}, {31'd0, Wen}, {31'd0, e_wen});
    check_eq({tag, ".ramaddr"}, ramaddr, e_addr);
    check_eq({tag, ".ramstore"}, ramstore, e_store);
    check_eq({tag, ".imemload"}, imemload, m_im);
    check_eq({tag, ".dmmload"}, dmmload, m_dm);
    @(posedge CLK);
    if (!rst_n) begin
      m_ph = PH_FETCH; m_im = 32'd0; m_dm = 32'd0;
    end else begin
      case (m_ph)
        PH_FETCH: if (!busy) begin m_im = rl; m_ph = PH_EXEC; end
        PH_EXEC:  m_ph = (op_load(op) || op_store(op)) ? PH_DATA : PH_FETCH;
        default:  if (!busy) begin
                    if (op_load(op)) m_dm = rl;
                    m_ph = PH_FETCH;
                  end
      endcase
    end
  endtask

  initial begin
    logic [5:0] op_r;
    nRST = 1'b0; busy_o = 1'b0; cuOP = 6'd0;
    imemaddr = 32'h0; dmmaddr = 32'h0; dmmstore = 32'h0; ramload = 32'h0;
    @(posedge CLK);
    @(posedge CLK);
    m_ph = PH_FETCH; m_im = 32'd0; m_dm = 32'd0;

    // reset held two cycles
    cycle(1'b0, 1'b0, 6'd0, 32'h00000040, 32'h0, 32'h0, 32'hDEADBEEF, "rst0");
    cycle(1'b0, 1'b0, 6'd0, 32'h00000044, 32'h0, 32'h0, 32'hDEADBEEF, "rst1");

    // stalled fetch
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, 6'd28, 32'hABCDABCD, 32'h0, 32'h0, 32'h12341234, "stall");
    cycle(1'b1, 1'b0, 6'd10, 32'hABCDABCD, 32'h0, 32'h0, 32'h12341234, "fetch_done");
    #1 check_eq("stall_imemload", imemload, 32'h12341234);

    // load LB
    cycle(1'b1, 1'b0, 6'd10, 32'hABCDABCD, 32'h56785678, 32'h0, 32'h0, "ld_exec");
    cycle(1'b1, 1'b0, 6'd10, 32'hABCDABCD, 32'h56785678, 32'h0, 32'h43214321, "ld_data");
    #1 check_eq("load_dmmload", dmmload, 32'h43214321);

    // store SW
    cycle(1'b1, 1'b0, 6'd17, 32'h00000100, 32'hABCDABCD, 32'h33333333, 32'h0BADF00D, "st_fetch");
    cycle(1'b1, 1'b0, 6'd17, 32'h00000100, 32'hABCDABCD, 32'h33333333, 32'h0, "st_exec");
    cycle(1'b1, 1'b1, 6'd17, 32'h00000100, 32'hABCDABCD, 32'h33333333, 32'h77777777, "st_wait");
    cycle(1'b1, 1'b0, 6'd17, 32'h00000100, 32'hABCDABCD, 32'h33333333, 32'h77777777, "st_data");
    #1 check_eq("store_dmmload", dmmload, 32'h43214321);

    // non-memory ADD, plus ERROR and an undefined code
    cycle(1'b1, 1'b0, 6'd28, 32'h11111111, 32'h22222222, 32'h0, 32'h00000013, "add_fetch");
    cycle(1'b1, 1'b0, 6'd28, 32'h11111111, 32'h22222222, 32'h0, 32'h0, "add_exec");
    cycle(1'b1, 1'b0, 6'd38, 32'h11111115, 32'h22222222, 32'h0, 32'h00000014, "err_fetch");
    cycle(1'b1, 1'b0, 6'd38, 32'h11111115, 32'h22222222, 32'h0, 32'h0, "err_exec");
    cycle(1'b1, 1'b0, 6'd63, 32'h11111119, 32'h22222222, 32'h0, 32'h00000015, "udf_fetch");
    cycle(1'b1, 1'b0, 6'd63, 32'h11111119, 32'h22222222, 32'h0, 32'h0, "udf_exec");

    // reset during a stalled load
    cycle(1'b1, 1'b0, 6'd14, 32'h200, 32'h300, 32'h0, 32'h00000016, "rm_fetch");
    cycle(1'b1, 1'b0, 6'd14, 32'h200, 32'h300, 32'h0, 32'h0, "rm_exec");
    cycle(1'b1, 1'b1, 6'd14, 32'h200, 32'h300, 32'h0, 32'h99999999, "rm_data");
    cycle(1'b0, 1'b1, 6'd14, 32'h200, 32'h300, 32'h0, 32'h99999999, "rm_rst");
    #1 check_eq("rm_dmmload", dmmload, 32'h0);
    cycle(1'b1, 1'b1, 6'd14, 32'h204, 32'h300, 32'h0, 32'h99999999, "rm_after");

    // randomized traffic; cuOP only changes while fetching
    op_r = 6'd0;
    for (int i = 0; i < 400; i++) begin
      if (m_ph == PH_FETCH)
        op_r = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(10, 17))
                                           : 6'($urandom_range(0, 63));
      cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) == 0), op_r,
            $urandom, $urandom, $urandom, $urandom, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
